qdma_arbiter: RTL and testbench
===============================

QDMA_ARBITER -- requirements
Module: qdma_arbiter

Interface
REQ-001 Parameter: WDOG, 8'd200, qclk cycles allowed in XFER before the transfer is aborted as an error.
REQ-002 qclk  input  1  the single clock; every flop updates on its rising edge.
REQ-003 RINIT  input  1  reset; synchronous and active-high.
REQ-004 req  input  4  per-channel DMA request; held by the requester until ack or err.
REQ-005 req_write  input  4  per-channel direction; 1=write to bus, 0=read from bus; sampled at grant.
REQ-006 TSACK  input  1  QBUS master bus-ownership indicator.
REQ-007 assert_data  input  1  master strobe marking completion of the write data phase.
REQ-008 latch_read_data  input  1  master strobe marking read data valid.
REQ-009 nxm  input  1  master non-existent-memory strobe.
REQ-010 dma_read  output  1  read request to the QBUS master.
REQ-011 dma_write  output  1  write request to the QBUS master.
REQ-012 sel  output  2  index of the granted channel; steers the address/data muxes.
REQ-013 gnt  output  4  one-hot grant; all zero when no channel is granted.
REQ-014 ack  output  4  one-cycle pulse on the granted channel at successful completion.
REQ-015 err  output  4  one-cycle pulse on the granted channel at nxm or watchdog abort.

Function
REQ-016 The block SHALL implement the states IDLE, XFER and DONE; all outputs SHALL be registered.
REQ-017 In IDLE with any req bit high, the block SHALL select a channel round-robin, starting the search at (last+1) mod 4, where last is the most recently granted channel.
REQ-018 The transition from IDLE to XFER SHALL take one clock edge.
- On that edge: sel and gnt are loaded.
- The direction is latched from req_write[sel].
- Exactly one of dma_write/dma_read is set.
- The watchdog is cleared.
REQ-019 In XFER, dma_read or dma_write SHALL be held high until the block sees the terminating strobe:
- assert_data for a write;
- latch_read_data for a read.
REQ-020 On the terminating strobe, at the next edge the block SHALL:
- clear dma_*;
- pulse ack[sel] for exactly one cycle;
- clear gnt;
- enter DONE.
REQ-021 On nxm in XFER, at the next edge the block SHALL clear dma_* and gnt, pulse err[sel], and enter DONE.
- If nxm and the terminating strobe coincide, err SHALL win and ack SHALL stay low.
REQ-022 The watchdog SHALL count XFER cycles; on reaching WDOG with no strobe and no nxm, the block SHALL behave exactly as for nxm.
REQ-023 The terminating strobe of the opposite direction SHALL be ignored in XFER.
- A write SHALL ignore latch_read_data.
- A read SHALL ignore assert_data.
REQ-024 The requester dropping req[sel] during XFER SHALL NOT abort the transfer; ack or err SHALL still be issued.
REQ-025 In DONE, the block SHALL update last to sel, stay while TSACK=1, and return to IDLE on the first cycle with TSACK=0.
- Consequently, at least one IDLE cycle SHALL separate any two grants.
REQ-026 ack, err and gnt SHALL each be one-hot or zero; dma_read and dma_write SHALL never both be high.
REQ-027 A req bit that is high in the same cycle as its own ack SHALL be treated as a new request, subject to round-robin.

Reset
REQ-028 When RINIT=1 at a clock edge, the block SHALL force the following at that edge, regardless of state, including mid-XFER:
- state=IDLE, dma_read=0, dma_write=0;
- sel=0, gnt=0, ack=0, err=0;
- watchdog=0, last=3, so that channel 0 has first priority after reset.
REQ-029 A transfer interrupted by RINIT SHALL produce neither ack nor err.

Verification
REQ-030 Single write on channel 2 (req=4'b0100, req_write[2]=1) -> gnt=4'b0100, sel=2, dma_write=1 one edge later; an assert_data pulse -> ack=4'b0100 for one cycle, dma_write=0.
REQ-031 req=4'b1111 held (each requester re-raises after its ack) -> grant order 0,1,2,3,0 from reset, each grant separated by an IDLE cycle.
REQ-032 Read on channel 1 with nxm pulsed in the same cycle as latch_read_data -> err=4'b0010, ack stays 0.
REQ-033 Read on channel 3 with no strobe -> dma_read high for exactly WDOG (200) cycles, then err=4'b1000.
REQ-034 RINIT=1 mid-XFER on channel 1 -> next cycle all outputs 0, no ack or err; a following req=4'b0011 grants channel 0 first.
REQ-035 TSACK held high for 10 cycles after ack -> no new gnt until the edge after TSACK falls.

Source files
------------

// File: rtl/qdma_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : qdma_arbiter
//  Description : Four-channel round-robin DMA arbiter in front of a QBUS
//                master. Grants one channel at a time, issues a read or write
//                request to the master and reports completion (ack) or
//                abort (err) back to the granted channel.
//  Revision    : 1.0  initial release
// ============================================================================
module qdma_arbiter #(
  parameter logic [7:0] WDOG = 8'd200
) (
  input  logic       qclk,
  input  logic       RINIT,
  input  logic [3:0] req,
  input  logic [3:0] req_write,
  input  logic       TSACK,
  input  logic       assert_data,
  input  logic       latch_read_data,
  input  logic       nxm,
  output logic       dma_read,
  output logic       dma_write,
  output logic [1:0] sel,
  output logic [3:0] gnt,
  output logic [3:0] ack,
  output logic [3:0] err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t     r_state;
  logic [1:0] r_last;
  logic [7:0] r_wdog;
  logic       r_dir;      // 1 = write transfer in progress
  logic       r_dma_read;
  logic       r_dma_write;
  logic [1:0] r_sel;
  logic [3:0] r_gnt;
  logic [3:0] r_ack;
  logic [3:0] r_err;

  logic [1:0] w_pick;
  logic       w_any;
  logic       w_strobe;
  logic       w_wdog_hit;

  // Round-robin search: first requesting channel at or after last+1.
  always_comb begin
    w_pick = 2'd0;
    w_any  = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      if (req[r_last + 2'(k) + 2'd1]) begin
        w_pick = r_last + 2'(k) + 2'd1;
        w_any  = 1'b1;
      end
    end
  end

  // Only the strobe matching the latched direction terminates a transfer.
  assign w_strobe   = r_dir ? assert_data : latch_read_data;
  assign w_wdog_hit = (r_wdog == (WDOG - 8'd1));

  // Arbiter state machine with fully registered outputs.
  always_ff @(posedge qclk) begin
    if (RINIT) begin
      r_state     <= S_IDLE;
      r_last      <= 2'd3;
      r_wdog      <= 8'd0;
      r_dir       <= 1'b0;
      r_dma_read  <= 1'b0;
      r_dma_write <= 1'b0;
      r_sel       <= 2'd0;
      r_gnt       <= 4'd0;
      r_ack       <= 4'd0;
      r_err       <= 4'd0;
    end else begin
      r_ack <= 4'd0;
      r_err <= 4'd0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_sel       <= w_pick;
            r_gnt       <= 4'b0001 << w_pick;
            r_dir       <= req_write[w_pick];
            r_dma_write <= req_write[w_pick];
            r_dma_read  <= ~req_write[w_pick];
            r_wdog      <= 8'd0;
            r_state     <= S_XFER;
          end
        end
        S_XFER: begin
          // nxm beats a coincident strobe; watchdog only fires when idle.
          if (nxm || w_strobe || w_wdog_hit) begin
            r_dma_read  <= 1'b0;
            r_dma_write <= 1'b0;
            r_gnt       <= 4'd0;
            r_state     <= S_DONE;
            if (nxm || !w_strobe) begin
              r_err <= 4'b0001 << r_sel;
            end else begin
              r_ack <= 4'b0001 << r_sel;
            end
          end else begin
            r_wdog <= r_wdog + 8'd1;
          end
        end
        S_DONE: begin
          r_last <= r_sel;
          if (!TSACK) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign dma_read  = r_dma_read;
  assign dma_write = r_dma_write;
  assign sel       = r_sel;
  assign gnt       = r_gnt;
  assign ack       = r_ack;
  assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_qdma_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_qdma_arbiter
//  Description : Directed, table-driven bench for qdma_arbiter plus hand
//                sequences for watchdog, mid-transfer reset and TSACK hold.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_qdma_arbiter;

  logic       qclk = 1'b0;
  logic       RINIT;
  logic [3:0] req;
  logic [3:0] req_write;
  logic       TSACK;
  logic       assert_data;
  logic       latch_read_data;
  logic       nxm;
  logic       dma_read;
  logic       dma_write;
  logic [1:0] sel;
  logic [3:0] gnt;
  logic [3:0] ack;
  logic [3:0] err;

  int checks = 0;
  int errors = 0;

  qdma_arbiter #(.WDOG(8'd200)) dut (
    .qclk(qclk), .RINIT(RINIT), .req(req), .req_write(req_write),
    .TSACK(TSACK), .assert_data(assert_data),
    .latch_read_data(latch_read_data), .nxm(nxm),
    .dma_read(dma_read), .dma_write(dma_write), .sel(sel),
    .gnt(gnt), .ack(ack), .err(err)
  );

  always #5 qclk = ~qclk;

  typedef struct {
    logic       rinit;
    logic [3:0] req;
    logic [3:0] rw;
    logic       ts;
    logic       ad;
    logic       lrd;
    logic       nxm;
    logic [15:0] exp;   // {dma_read, dma_write, sel, gnt, ack, err}
  } vec_t;

  vec_t vecs[25];

  function automatic logic [15:0] e(input logic dr, input logic dw,
                                     input logic [1:0] s, input logic [3:0] g,
                                     input logic [3:0] a, input logic [3:0] r);
    return {dr, dw, s, g, a, r};
  endfunction

  function automatic vec_t v(input logic ri, input logic [3:0] rq,
                             input logic [3:0] rw, input logic ts,
                             input logic ad, input logic lrd, input logic nx,
                             input logic [15:0] ex);
    vec_t t;
    t.rinit = ri; t.req = rq; t.rw = rw; t.ts = ts;
    t.ad = ad; t.lrd = lrd; t.nxm = nx; t.exp = ex;
    return t;
  endfunction

  task automatic drive(input logic ri, input logic [3:0] rq, input logic [3:0] rw,
                       input logic ts, input logic ad, input logic lrd,
                       input logic nx);
    RINIT = ri; req = rq; req_write = rw; TSACK = ts;
    assert_data = ad; latch_read_data = lrd; nxm = nx;
  endtask

  task automatic step();
    @(posedge qclk);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] exp);
    logic [15:0] act;
    act = {dma_read, dma_write, sel, gnt, ack, err};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got dr=%b dw=%b sel=%0d gnt=%b ack=%b err=%b, want dr=%b dw=%b sel=%0d gnt=%b ack=%b err=%b",
               name, act[15], act[14], act[13:12], act[11:8], act[7:4], act[3:0],
               exp[15], exp[14], exp[13:12], exp[11:8], exp[7:4], exp[3:0]);
    end
  endtask

  initial begin
    int cnt;
    drive(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Write on ch2 (read strobe ignored), read on ch1 with nxm+strobe and
    // req dropped, then round-robin from reset with all four requesting.
    vecs[0]  = v(1, 4'b0000, 4'b0000, 0, 0, 0, 0, e(0, 0, 0, 4'b0000, 4'b0000, 4'b0000));
    vecs[1]  = v(0, 4'b0100, 4'b0100, 0, 0, 0, 0, e(0, 1, 2, 4'b0100, 4'b0000, 4'b0000));
    vecs[2]  = v(0, 4'b0100, 4'b0100, 0, 0, 1, 0, e(0, 1, 2, 4'b0100, 4'b0000, 4'b0000));
    vecs[3]  = v(0, 4'b0100, 4'b0100, 0, 1, 0, 0, e(0, 0, 2, 4'b0000, 4'b0100, 4'b0000));
    vecs[4]  = v(0, 4'b0000, 4'b0000, 0, 0, 0, 0, e(0, 0, 2, 4'b0000, 4'b0000, 4'b0000));
    vecs[5]  = v(0, 4'b0010, 4'b0000, 0, 0, 1, 0, e(1, 0, 1, 4'b0010, 4'b0000, 4'b0000));
    vecs[6]  = v(0, 4'b0010, 4'b0000, 0, 1, 0, 0, e(1, 0, 1, 4'b0010, 4'b0000, 4'b0000));
    vecs[7]  = v(0, 4'b0000, 4'b0000, 0, 0, 1, 1, e(0, 0, 1, 4'b0000, 4'b0000, 4'b0010));
    vecs[8]  = v(0, 4'b0000, 4'b0000, 0, 0, 0, 0, e(0, 0, 1, 4'b0000, 4'b0000, 4'b0000));
    vecs[9]  = v(1, 4'b1111, 4'b0000, 0, 0, 0, 0, e(0, 0, 0, 4'b0000, 4'b0000, 4'b0000));
    vecs[10] = v(0, 4'b1111, 4'b0000, 0, 0, 0, 0, e(1, 0, 0, 4'b0001, 4'b0000, 4'b0000));
    vecs[11] = v(0, 4'b1111, 4'b0000, 0, 0, 1, 0, e(0, 0, 0, 4'b0000, 4'b0001, 4'b0000));
    vecs[12] = v(0, 4'b1111, 4'b0000, 0, 0, 0, 0, e(0, 0, 0, 4'b0000, 4'b0000, 4'b0000));
    vecs[13] = v(0, 4'b1111, 4'b0000, 0, 0, 0, 0, e(1, 0, 1, 4'b0010, 4'b0000, 4'b0000));
    vecs[14] = v(0, 4'b1111, 4'b0000, 0, 0, 1, 0, e(0, 0, 1, 4'b0000, 4'b0010, 4'b0000));
    vecs[15] = v(0, 4'b1111, 4'b0000, 0, 0, 0, 0, e(0, 0, 1, 4'b0000, 4'b0000, 4'b0000));
    vecs[16] = v(0, 4'b1111, 4'b0000, 0, 0, 0, 0, e(1, 0, 2, 4'b0100, 4'b0000, 4'b0000));
    vecs[17] = v(0, 4'b1111, 4'b0000, 0, 0, 1, 0, e(0, 0, 2, 4'b0000, 4'b0100, 4'b0000));
    vecs[18] = v(0, 4'b1111, 4'b0000, 0, 0, 0, 0, e(0, 0, 2, 4'b0000, 4'b0000, 4'b0000));
    vecs[19] = v(0, 4'b1111, 4'b0000, 0, 0, 0, 0, e(1, 0, 3, 4'b1000, 4'b0000, 4'b0000));
    vecs[20] = v(0, 4'b1111, 4'b0000, 0, 0, 1, 0, e(0, 0, 3, 4'b0000, 4'b1000, 4'b0000));
    vecs[21] = v(0, 4'b1111, 4'b0000, 0, 0, 0, 0, e(0, 0, 3, 4'b0000, 4'b0000, 4'b0000));
    vecs[22] = v(0, 4'b1111, 4'b0000, 0, 0, 0, 0, e(1, 0, 0, 4'b0001, 4'b0000, 4'b0000));
    vecs[23] = v(0, 4'b1111, 4'b0000, 0, 0, 1, 0, e(0, 0, 0, 4'b0000, 4'b0001, 4'b0000));
    vecs[24] = v(0, 4'b0000, 4'b0000, 0, 0, 0, 0, e(0, 0, 0, 4'b0000, 4'b0000, 4'b0000));

    for (int i = 0; i < 25; i++) begin
      drive(vecs[i].rinit, vecs[i].req, vecs[i].rw, vecs[i].ts,
            vecs[i].ad, vecs[i].lrd, vecs[i].nxm);
      step();
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Watchdog: read on ch3 with no strobe.
    drive(1, 4'b0000, 4'b0000, 0, 0, 0, 0); step();
    drive(0, 4'b1000, 4'b0000, 0, 0, 0, 0); step();
    check("wdog_grant", e(1, 0, 3, 4'b1000, 4'b0000, 4'b0000));
    cnt = 1;
    for (int i = 0; i < 300 && dma_read; i++) begin
      step();
      if (dma_read) cnt++;
    end
    checks++;
    if (cnt != 200) begin
      errors++;
      $display("FAIL wdog_len: dma_read high %0d cycles, want 200", cnt);
    end
    check("wdog_err", e(0, 0, 3, 4'b0000, 4'b0000, 4'b1000));

    // Reset in the middle of a ch1 transfer.
    drive(1, 4'b0000, 4'b0000, 0, 0, 0, 0); step();
    drive(0, 4'b0010, 4'b0000, 0, 0, 0, 0); step();
    check("rst_grant", e(1, 0, 1, 4'b0010, 4'b0000, 4'b0000));
    step();
    drive(1, 4'b0010, 4'b0000, 0, 0, 1, 0); step();
    check("rst_mid", e(0, 0, 0, 4'b0000, 4'b0000, 4'b0000));
    drive(0, 4'b0011, 4'b0000, 0, 0, 0, 0); step();
    check("rst_regrant", e(1, 0, 0, 4'b0001, 4'b0000, 4'b0000));

    // TSACK held high after ack delays the next grant.
    drive(1, 4'b0000, 4'b0000, 0, 0, 0, 0); step();
    drive(0, 4'b0001, 4'b0001, 0, 0, 0, 0); step();
    check("ts_grant", e(0, 1, 0, 4'b0001, 4'b0000, 4'b0000));
    drive(0, 4'b0001, 4'b0001, 1, 1, 0, 0); step();
    check("ts_ack", e(0, 0, 0, 4'b0000, 4'b0001, 4'b0000));
    drive(0, 4'b0001, 4'b0001, 1, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("ts_hold%0d", i), e(0, 0, 0, 4'b0000, 4'b0000, 4'b0000));
    end
    drive(0, 4'b0001, 4'b0001, 0, 0, 0, 0); step();
    check("ts_fall", e(0, 0, 0, 4'b0000, 4'b0000, 4'b0000));
    step();
    check("ts_regrant", e(0, 1, 0, 4'b0001, 4'b0000, 4'b0000));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
